// File: rtl/operand_fetch.sv
// operand_fetch: register file, pending-write scoreboard and registered ALU operands.
// Optional macro OPERAND_FETCH_BYPASS_EN forwards same-cycle write-back data to sources.
module operand_fetch #(
    parameter int D_WIDTH = 32,
    parameter int R_ADDR  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [R_ADDR-1:0]  in_rs1,
    input  logic [R_ADDR-1:0]  in_rs2,
    input  logic [R_ADDR-1:0]  in_rd,
    input  logic [3:0]         in_alu_op,
    input  logic [D_WIDTH-1:0] in_imm,
    input  logic               in_use_imm,
    input  logic               in_we,
    input  logic               wb_en,
    input  logic [R_ADDR-1:0]  wb_addr,
    input  logic [D_WIDTH-1:0] wb_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_alu_op,
    output logic [D_WIDTH-1:0] out_a,
    output logic [D_WIDTH-1:0] out_b,
    output logic [R_ADDR-1:0]  out_rd,
    output logic               out_we
);

    localparam int NREG = 1 << R_ADDR;

    logic [D_WIDTH-1:0] rf [NREG];
    logic [NREG-1:0]    pend;
    logic [NREG-1:0]    pend_nxt;

    logic               rs1_busy;
    logic               rs2_busy;
    logic               rd_busy;
    logic               hazard;
    logic               accept;
    logic [D_WIDTH-1:0] rs1_val;
    logic [D_WIDTH-1:0] rs2_val;

`ifdef OPERAND_FETCH_BYPASS_EN
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = wb_en && (wb_addr == in_rs1);
    assign rs2_hit  = wb_en && (wb_addr == in_rs2);
    assign rs1_busy = pend[in_rs1] && (in_rs1 != '0) && !rs1_hit;
    assign rs2_busy = pend[in_rs2] && (in_rs2 != '0) && !rs2_hit;
    assign rs1_val  = (in_rs1 == '0) ? '0 :
                      rs1_hit ? wb_data : rf[in_rs1];
    assign rs2_val  = (in_rs2 == '0) ? '0 :
                      rs2_hit ? wb_data : rf[in_rs2];
`else
    assign rs1_busy = pend[in_rs1] && (in_rs1 != '0);
    assign rs2_busy = pend[in_rs2] && (in_rs2 != '0);
    assign rs1_val  = (in_rs1 == '0) ? '0 : rf[in_rs1];
    assign rs2_val  = (in_rs2 == '0) ? '0 : rf[in_rs2];
`endif

    // WAW check is never bypassed: rd must be fully retired first
    assign rd_busy  = in_we && (in_rd != '0) && pend[in_rd];
    assign hazard   = rs1_busy || (!in_use_imm && rs2_busy) || rd_busy;
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Clears first so a same-cycle set on the same address wins
    always_comb begin
        pend_nxt = pend;
        if (wb_en) begin
            pend_nxt[wb_addr] = 1'b0;
        end
        if (flush && out_valid && out_we) begin
            pend_nxt[out_rd] = 1'b0;
        end
        if (accept && in_we && (in_rd != '0)) begin
            pend_nxt[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_alu_op <= '0;
            out_a      <= '0;
            out_b      <= '0;
            out_rd     <= '0;
            out_we     <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_alu_op <= in_alu_op;
            out_a      <= rs1_val;
            out_b      <= in_use_imm ? in_imm : rs2_val;
            out_rd     <= in_rd;
            out_we     <= in_we;
        end else if (flush || out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed test-plan steps followed by random traffic
// checked against a cycle-level reference model of the operand-fetch rules.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [3:0]  in_alu_op;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic        in_we;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_rd;
    logic        out_we;

    int checks = 0;
    int failures = 0;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alu_op(in_alu_op), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_we(in_we),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_a(out_a), .out_b(out_b),
        .out_rd(out_rd), .out_we(out_we)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_rf [32];
    bit          m_pend [32];
    logic        m_ov;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_rd;
    logic        m_we;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
        m_ov = 0; m_op = 0; m_a = 0; m_b = 0; m_rd = 0; m_we = 0;
    endtask

    function automatic bit m_hit(logic [4:0] a);
`ifdef OPERAND_FETCH_BYPASS_EN
        return wb_en && wb_addr == a && a != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_src_busy(logic [4:0] a);
        return a != 0 && m_pend[a] && !m_hit(a);
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] a);
        if (a == 0) return 32'h0;
        if (m_hit(a)) return wb_data;
        return m_rf[a];
    endfunction

    // one clock: check in_ready, advance model, check registered outputs
    task automatic step();
        bit hz, rdy, acc;
        logic [31:0] va, vb;
        #1;
        if (rst) m_reset();
        hz = m_src_busy(in_rs1) || (!in_use_imm && m_src_busy(in_rs2))
             || (in_we && in_rd != 0 && m_pend[in_rd]);
        rdy = !flush && !hz && (!m_ov || out_ready);
        chk("in_ready", {127'h0, in_ready}, {127'h0, rdy});
        acc = in_valid && rdy;
        va = m_read(in_rs1);
        vb = in_use_imm ? in_imm : m_read(in_rs2);
        @(posedge clk);
        #1;
        if (!rst) begin
            if (flush && m_ov && m_we) m_pend[m_rd] = 1'b0;
            if (wb_en) m_pend[wb_addr] = 1'b0;
            if (acc && in_we && in_rd != 0) m_pend[in_rd] = 1'b1;
            if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
            if (acc) begin
                m_ov = 1; m_op = in_alu_op; m_a = va; m_b = vb;
                m_rd = in_rd; m_we = in_we;
            end else if (flush || out_ready) begin
                m_ov = 0;
            end
        end
        chk("outputs",
            {53'h0, out_valid, out_alu_op, out_a, out_b, out_rd, out_we},
            {53'h0, m_ov, m_op, m_a, m_b, m_rd, m_we});
    endtask

    task automatic idle();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_alu_op = 0; in_imm = 0; in_use_imm = 0; in_we = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
    endtask

    initial begin
        idle();
        m_reset();
        // reset with a pending instruction and backpressure
        in_valid = 1; out_ready = 0; in_we = 1; in_rd = 3; in_rs1 = 1;
        step();
        step();
        chk("rst_out", {out_valid, out_alu_op, out_a, out_b, out_rd, out_we}, 0);
        rst = 0;
        idle();
        #1 chk("rst_rdy", {127'h0, in_ready}, 1);
        in_valid = 1;
        step();
        chk("zero_read", {out_valid, out_a, out_b}, {1'b1, 64'h0});

        // write-back then immediate
        idle(); wb_en = 1; wb_addr = 3; wb_data = 32'h0000_00A5;
        step();
        idle(); in_valid = 1; in_rs1 = 3; in_use_imm = 1;
        in_imm = 32'hFFFF_FFFC;
        step();
        chk("wb_imm", {out_valid, out_a, out_b},
            {1'b1, 32'h0000_00A5, 32'hFFFF_FFFC});

        // RAW stall on rs2=5
        idle(); in_valid = 1; in_we = 1; in_rd = 5; in_alu_op = 1;
        step();
        in_we = 0; in_rd = 0; in_rs2 = 5; in_alu_op = 2;
        #1 chk("raw_stall", {127'h0, in_ready}, 0);
        step();
        step();
        wb_en = 1; wb_addr = 5; wb_data = 32'h55;
`ifdef OPERAND_FETCH_BYPASS_EN
        #1 chk("raw_byp_rdy", {127'h0, in_ready}, 1);
        step();
        wb_en = 0;
`else
        #1 chk("raw_wb_rdy", {127'h0, in_ready}, 0);
        step();
        wb_en = 0;
        #1 chk("raw_late_rdy", {127'h0, in_ready}, 1);
        step();
`endif
        chk("raw_out", {out_valid, out_alu_op, out_b}, {1'b1, 4'd2, 32'h55});

        // backpressure for 3 cycles
        idle(); out_ready = 0; in_valid = 1; in_rs1 = 3;
        in_use_imm = 1; in_imm = 32'h10; in_alu_op = 3;
        repeat (3) begin
            #1 chk("bp_rdy", {127'h0, in_ready}, 0);
            step();
            chk("bp_hold", {out_valid, out_alu_op, out_a, out_b},
                {1'b1, 4'd2, 32'h0, 32'h55});
        end
        out_ready = 1;
        step();
        chk("bp_release", {out_valid, out_alu_op, out_a, out_b},
            {1'b1, 4'd3, 32'hA5, 32'h10});

        // flush of a held rd=7 writer
        idle(); in_valid = 1; in_we = 1; in_rd = 7; in_use_imm = 1;
        in_alu_op = 4;
        step();
        in_we = 0; in_rd = 0; in_rs1 = 7; flush = 1;
        #1 chk("flush_rdy", {127'h0, in_ready}, 0);
        step();
        chk("flush_out", {127'h0, out_valid}, 0);
        flush = 0;
        #1 chk("post_flush_rdy", {127'h0, in_ready}, 1);
        step();
        chk("post_flush", {out_valid, out_a}, {1'b1, 32'h0});

        // address zero
        idle(); in_valid = 1; in_we = 1; in_rd = 0;
        step();
        in_we = 0; wb_en = 1; wb_addr = 0; wb_data = 32'h1234;
        #1 chk("zero_rdy", {127'h0, in_ready}, 1);
        step();
        chk("zero_a", {out_valid, out_a}, {1'b1, 32'h0});
        wb_en = 0;
        step();
        chk("zero_a2", {out_valid, out_a}, {1'b1, 32'h0});

        // reset in the middle of a stall
        idle(); in_valid = 1; in_we = 1; in_rd = 9; in_use_imm = 1;
        step();
        in_we = 0; in_rd = 0; in_rs1 = 9; out_ready = 0;
        step();
        rst = 1;
        step();
        rst = 0; out_ready = 1;
        #1 chk("mid_rst_rdy", {127'h0, in_ready}, 1);
        step();
        chk("mid_rst_a", {out_valid, out_a}, {1'b1, 32'h0});
        in_rs1 = 3;
        step();
        chk("rf_cleared", {out_valid, out_a}, {1'b1, 32'h0});

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_rs1     = 5'($urandom_range(0, 7));
            in_rs2     = 5'($urandom_range(0, 7));
            in_rd      = 5'($urandom_range(0, 7));
            in_alu_op  = 4'($urandom);
            in_imm     = $urandom;
            in_use_imm = 1'($urandom_range(0, 1));
            in_we      = 1'($urandom_range(0, 1));
            wb_en      = ($urandom_range(0, 2) == 0);
            wb_addr    = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            flush      = ($urandom_range(0, 15) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 199) == 0);
            step();
            rst = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage directly upstream of the ALU. Accepts decoded instructions from decode and holds the 32-entry register file. It also tracks pending writes in a scoreboard and stalls on RAW/WAW hazards. It presents registered `alu_op`, `a` and `b` operands to the ALU through a valid/ready handshake, and receives results on a write-back port.

## Interface
- `D_WIDTH`, 32, datapath width; must match the ALU's `D_WIDTH`.
- `R_ADDR`, 5, register address width; the file has 2^R_ADDR entries, and entry 0 is hardwired zero.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a decoded instruction is present.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_rs1`, `in_rs2`, `in_rd`  in  R_ADDR each  source and destination register addresses.
- `in_alu_op`  in  4  ALU opcode, passed through unchanged.
- `in_imm`  in  D_WIDTH  immediate, already sign-extended by decode.
- `in_use_imm`  in  1  selects `in_imm` instead of rs2 for operand b.
- `in_we`  in  1  instruction writes `in_rd`.
- `wb_en`  in  1  write-back strobe.
- `wb_addr`  in  R_ADDR  write-back destination register.
- `wb_data`  in  D_WIDTH  write-back data.
- `flush`  in  1  discards the instruction held in the output register.
- `out_valid`  out  1  operands are valid toward the ALU.
- `out_ready`  in  1  the ALU/execute stage consumes this cycle.
- `out_alu_op`  out  4  goes to ALU `alu_op`.
- `out_a`  out  D_WIDTH  goes to ALU `a`.
- `out_b`  out  D_WIDTH  goes to ALU `b`.
- `out_rd`  out  R_ADDR  destination register, carried forward.
- `out_we`  out  1  write-enable, carried forward.

## Operation
- **Register file:**
  - Write on a clock edge when `wb_en` is high and `wb_addr != 0`.
  - Writes to address 0 are ignored, and a read of address 0 always returns 0.
- **Scoreboard:** one pending bit per register.
  - Set on accept when `in_we` is high and `in_rd != 0`.
  - Cleared on `wb_en` for `wb_addr`.
  - If the set and the clear hit the same address in the same cycle, set wins.
- **Hazard:** asserted when any of the following holds:
  - rs1 is busy;
  - `in_use_imm` is low and rs2 is busy;
  - `in_we` is high and rd is busy.
  - A register is busy when its pending bit is set and the address is not 0 (the busy definition is qualified by the Configuration macro).
- **Ready:** `in_ready = !flush && !hazard && (!out_valid || out_ready)`.
- **Accept:** occurs when `in_valid && in_ready`. On accept the output register loads:
  - `out_a` ← rs1 value;
  - `out_b` ← `in_use_imm ? in_imm : rs2 value`;
  - `out_alu_op`, `out_rd`, `out_we` ← their inputs;
  - `out_valid` ← 1.
- **Drain:** when `out_valid && out_ready` and there is no accept in the same cycle, `out_valid` ← 0.
- **Flush:**
  - `out_valid` ← 0.
  - If the held instruction had `out_valid && out_we`, its `out_rd` pending bit is cleared.
  - No accept occurs in a flush cycle.
  - A `wb_en` in the same cycle is still honoured.
- **Output stability:** outputs hold their values while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N.
- Full throughput is one instruction per cycle when there are no hazards and `out_ready` is held high.
- All outputs are registered. `in_ready` is combinational from `flush`, `out_ready`, scoreboard state and the `in_*` addresses.
- A write-back at edge N updates the register file and scoreboard at edge N; a stalled instruction whose hazard clears at edge N is accepted at edge N or later (see Configuration).
- **Reset:**
  - All register-file entries are 0 and all pending bits are 0.
  - `out_valid=0`, `out_a=0`, `out_b=0`, `out_alu_op=0`, `out_rd=0`, `out_we=0`.
  - `in_ready` evaluates to 1 after reset.
  - Reset mid-stall drops the held instruction; no write-back is remembered.

## Configuration
- `OPERAND_FETCH_BYPASS_EN` **defined:**
  - A source register whose pending bit is set is not busy if `wb_en && wb_addr == rs` in the same cycle.
  - Its operand takes `wb_data` combinationally, so the instruction is accepted in the write-back cycle.
- **Undefined:**
  - Any set pending bit means busy.
  - Reads come only from the stored array, so issue happens one cycle after write-back.
  - In this configuration there is no combinational path from `wb_data` to the output register.

## Test plan
- **Reset:** assert `rst` with `in_valid=1`, `out_ready=0`.
  - → `out_valid=0` and all outputs 0.
  - After deassertion, `in_ready=1`, and any rs=0 reads 0.
- **Write-back then immediate:** write back `wb_addr=3`, `wb_data=0x0000_00A5`, then accept `rs1=3`, `in_use_imm=1`, `in_imm=0xFFFF_FFFC`, `alu_op=0000`.
  - → next cycle `out_a=0xA5`, `out_b=0xFFFF_FFFC`, `out_valid=1`.
- **RAW stall:** accept an instruction with `in_we=1`, `rd=5`; the next instruction reads `rs2=5`.
  - → `in_ready=0` until write-back to 5.
  - With bypass: accepted in the `wb` cycle with `out_b=wb_data`.
  - Without bypass: accepted one cycle later.
- **Backpressure:** hold `out_ready=0` for 3 cycles with `out_valid=1`.
  - → outputs stable, `in_ready=0`.
  - On `out_ready=1` with `in_valid=1`, the next instruction is loaded in the same cycle and `out_valid` stays 1.
- **Flush:** the held instruction has `out_we=1`, `out_rd=7`; assert `flush`.
  - → `out_valid=0` next cycle, `in_ready=0` during the flush cycle.
  - A following instruction reading `rs1=7` is accepted without waiting for write-back.
- **Address zero:** `in_we=1` with `rd=0`, then `rs1=0`, and `wb_en` with `wb_addr=0`, `wb_data=0x1234`.
  - → no stall, `out_a=0`.
